e_mdu: RTL and testbench

E_MDU -- requirements
Module: e_mdu

---
 rtl/e_mdu_pkg.sv | 47 ++++
 rtl/e_mdu.sv | 83 ++++++++
 tb/tb_e_mdu.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_pkg.sv
// Shared pipeline constants for the MDU: opcode/funct encodings, latencies and
// the combinational multiply/divide datapath used to fill the shadow result.
package e_mdu_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  typedef enum logic [5:0] {
    FN_MFHI  = 6'b010000,
    FN_MTHI  = 6'b010001,
    FN_MFLO  = 6'b010010,
    FN_MTLO  = 6'b010011,
    FN_MULT  = 6'b011000,
    FN_MULTU = 6'b011001,
    FN_DIV   = 6'b011010,
    FN_DIVU  = 6'b011011
  } funct_e;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int CNT_W    = 4;

  // Returns {HI, LO}. Signed division works on magnitudes so that
  // 0x80000000 / -1 falls out naturally as LO=0x80000000, HI=0.
  function automatic logic [63:0] md_calc(input logic [5:0] fn,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] ma, mb, q, r;
    logic        sa, sb;
    p  = '0;
    sa = (fn == FN_DIV) && a[31];
    sb = (fn == FN_DIV) && b[31];
    ma = sa ? -a : a;
    mb = sb ? -b : b;
    q  = (mb == '0) ? '0 : ma / mb;
    r  = (mb == '0) ? '0 : ma % mb;
    case (fn)
      FN_MULT:  p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      FN_MULTU: p = {32'b0, a} * {32'b0, b};
      FN_DIV,
      FN_DIVU:  p = {sa ? -r : r, (sa ^ sb) ? -q : q};
      default:  p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult/div with HI/LO registers,
// mthi/mtlo writes and combinational mfhi/mflo read port.
module e_mdu
  import e_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  E_op,
  input  logic [5:0]  E_fuc,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        E_en,
  output logic        E_MDU_start,
  output logic        E_MDU_busy,
  output logic [31:0] E_MDU_out,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [63:0]      shd_q, shd_d;
  logic             dz_q, dz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_sp, is_mul, is_div, is_mthi, is_mtlo, is_mfhi, is_mflo, issue;

  assign is_sp   = (E_op == OP_SPECIAL);
  assign is_mul  = is_sp && (E_fuc == FN_MULT || E_fuc == FN_MULTU);
  assign is_div  = is_sp && (E_fuc == FN_DIV  || E_fuc == FN_DIVU);
  assign is_mthi = is_sp && (E_fuc == FN_MTHI);
  assign is_mtlo = is_sp && (E_fuc == FN_MTLO);
  assign is_mfhi = is_sp && (E_fuc == FN_MFHI);
  assign is_mflo = is_sp && (E_fuc == FN_MFLO);

  assign E_MDU_busy  = (cnt_q != '0);
  // reset_n gates the issue so nothing is reported as accepted while held in reset.
  assign issue       = E_en && !E_MDU_busy && reset_n;
  assign E_MDU_start = issue && (is_mul || is_div);

  assign E_HI      = hi_q;
  assign E_LO      = lo_q;
  assign E_MDU_out = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);

  // NOTE: every variable gets its hold value first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    shd_d = shd_q;
    dz_d  = dz_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (E_MDU_start) begin
      cnt_d = is_mul ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
      shd_d = md_calc(E_fuc, E_A, E_B);
      dz_d  = is_div && (E_B == '0);
    end else if (E_MDU_busy) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1) && !dz_q) begin
        hi_d = shd_q[63:32];
        lo_d = shd_q[31:0];
      end
    end
    if (issue && is_mthi) hi_d = E_A;
    if (issue && is_mtlo) lo_d = E_A;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      shd_q <= '0;
      dz_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      shd_q <= shd_d;
      dz_q  <= dz_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed corner cases plus random operations
// compared against a 64-bit arithmetic model of HI/LO.
module tb_e_mdu;

  localparam logic [5:0] T_MFHI = 6'b010000, T_MTHI = 6'b010001;
  localparam logic [5:0] T_MFLO = 6'b010010, T_MTLO = 6'b010011;
  localparam logic [5:0] T_MULT = 6'b011000, T_MULTU = 6'b011001;
  localparam logic [5:0] T_DIV  = 6'b011010, T_DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  E_op, E_fuc;
  logic [31:0] E_A, E_B;
  logic        E_en;
  logic        E_MDU_start, E_MDU_busy;
  logic [31:0] E_MDU_out, E_HI, E_LO;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] hi_m = '0, lo_m = '0;

  e_mdu dut (
    .clk(clk), .reset_n(reset_n), .E_op(E_op), .E_fuc(E_fuc),
    .E_A(E_A), .E_B(E_B), .E_en(E_en),
    .E_MDU_start(E_MDU_start), .E_MDU_busy(E_MDU_busy),
    .E_MDU_out(E_MDU_out), .E_HI(E_HI), .E_LO(E_LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint          s;
    longint unsigned u;
    case (fn)
      T_MULT:  begin s = longint'($signed(a)) * longint'($signed(b)); {hi_m, lo_m} = s; end
      T_MULTU: begin u = {32'b0, a} * {32'b0, b}; {hi_m, lo_m} = u; end
      T_DIV: if (b != 0) begin
        s = longint'($signed(a)) / longint'($signed(b)); lo_m = s[31:0];
        s = longint'($signed(a)) % longint'($signed(b)); hi_m = s[31:0];
      end
      T_DIVU: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      default: ;
    endcase
  endtask

  // Issues one mult/div, checks start, busy length and final HI/LO.
  task automatic run_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    int n, lat;
    lat = (fn == T_MULT || fn == T_MULTU) ? 5 : 10;
    E_op = 6'd0; E_fuc = fn; E_A = a; E_B = b; E_en = 1'b1;
    #1;
    check("start", E_MDU_start, 1);
    tick();
    E_en = 1'b0; E_fuc = 6'd0;
    n = 0;
    while (E_MDU_busy && n < 20) begin
      tick();
      n++;
    end
    check("busy_len", n, lat);
    model(fn, a, b);
    check("hi", E_HI, hi_m);
    check("lo", E_LO, lo_m);
  endtask

  task automatic move_to(input logic [5:0] fn, input logic [31:0] a);
    E_op = 6'd0; E_fuc = fn; E_A = a; E_en = 1'b1;
    tick();
    E_en = 1'b0;
    if (fn == T_MTHI) hi_m = a; else lo_m = a;
  endtask

  task automatic read_chk(input logic [5:0] fn, input logic [31:0] exp, input string tag);
    E_op = 6'd0; E_fuc = fn; E_en = 1'b1;
    #1;
    check(tag, E_MDU_out, exp);
    E_en = 1'b0; E_fuc = 6'd0;
  endtask

  initial begin
    logic [5:0] fn;
    logic [31:0] a, b;
    reset_n = 1'b0; E_op = 6'd0; E_fuc = T_MULT; E_A = '0; E_B = '0; E_en = 1'b1;
    #12;
    check("rst_busy", E_MDU_busy, 0);
    check("rst_start", E_MDU_start, 0);
    check("rst_hi", E_HI, 0);
    check("rst_lo", E_LO, 0);
    E_en = 1'b0; E_fuc = T_MFLO;
    #1;
    check("rst_out", E_MDU_out, 0);
    tick();
    reset_n = 1'b1;
    tick();

    run_md(T_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult_hi_const", E_HI, 32'hFFFF_FFFF);
    check("mult_lo_const", E_LO, 32'hFFFF_FFFA);
    run_md(T_MULTU, 32'hFFFF_FFFE, 32'd3);
    check("multu_hi_const", E_HI, 32'h2);
    check("multu_lo_const", E_LO, 32'hFFFF_FFFA);
    run_md(T_DIV, -32'sd7, 32'd2);
    check("div_lo_const", E_LO, 32'hFFFF_FFFD);
    check("div_hi_const", E_HI, 32'hFFFF_FFFF);
    run_md(T_DIVU, 32'd100, 32'd0);
    check("divz_hi", E_HI, 32'hFFFF_FFFF);
    check("divz_lo", E_LO, 32'hFFFF_FFFD);
    run_md(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("ovf_lo", E_LO, 32'h8000_0000);
    check("ovf_hi", E_HI, 32'h0);

    move_to(T_MTHI, 32'h1234);
    read_chk(T_MFHI, 32'h1234, "mthi_mfhi");
    move_to(T_MTLO, 32'h5678);
    read_chk(T_MFLO, 32'h5678, "mtlo_mflo");

    // mtlo attempted while busy must not land.
    E_op = 6'd0; E_fuc = T_MULTU; E_A = 32'd7; E_B = 32'd9; E_en = 1'b1;
    tick();
    E_fuc = T_MTLO; E_A = 32'hDEAD_BEEF;
    tick();
    E_en = 1'b0;
    check("mtlo_busy", E_LO, 32'h5678);
    repeat (8) tick();
    model(T_MULTU, 32'd7, 32'd9);
    check("mtlo_busy_final", E_LO, lo_m);

    // Completion cycle: new LO readable and a new mult accepted immediately.
    run_md(T_DIVU, 32'd1000, 32'd7);
    read_chk(T_MFLO, 32'd142, "mflo_at_fall");
    run_md(T_MULT, 32'd6, 32'd7);
    run_md(T_MULT, -32'sd6, 32'd7);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0: fn = T_MULT;  1: fn = T_MULTU;
        2: fn = T_DIV;   3: fn = T_DIVU;
        4: fn = T_MTHI;  default: fn = T_MTLO;
      endcase
      a = $urandom;
      b = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom;
      if (fn == T_MTHI || fn == T_MTLO) move_to(fn, a);
      else run_md(fn, a, b);
      read_chk(T_MFHI, hi_m, "rnd_mfhi");
      read_chk(T_MFLO, lo_m, "rnd_mflo");
    end

    // Reset during cycle 3 of a div cancels it completely.
    E_op = 6'd0; E_fuc = T_DIV; E_A = 32'd99; E_B = 32'd4; E_en = 1'b1;
    tick();
    E_en = 1'b0;
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", E_MDU_busy, 0);
    check("mid_rst_hi", E_HI, 0);
    check("mid_rst_lo", E_LO, 0);
    E_fuc = T_MULT; E_en = 1'b1;
    #1;
    check("mid_rst_start", E_MDU_start, 0);
    E_en = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (12) tick();
    check("late_busy", E_MDU_busy, 0);
    check("late_hi", E_HI, 0);
    check("late_lo", E_LO, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
